// File: rtl/div_pkg.sv
// Shared types and constants for the radix-4 sequential divider.
package div_pkg;

    // Controller states: accept operands, iterate digits, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default divisor / quotient / remainder width.
    localparam int DIV_W_DEFAULT = 8;

    // Step-counter width for the default width: holds 0 .. W/2-1.
    localparam int DIV_CNT_W = $clog2(DIV_W_DEFAULT / 2) + 1;

    // Step-counter width for an arbitrary (even, >= 4) width.
    function automatic int cnt_width(input int w);
        return $clog2(w / 2) + 1;
    endfunction

endpackage

// File: rtl/div_r4_step.sv
// One radix-4 restoring division step: picks the largest digit q in 0..3
// with R' - q*d >= 0 and returns the reduced partial remainder.
module div_r4_step #(
    parameter int W = 8
) (
    input  logic [W+1:0] r_shift,   // R' = {R, next two dividend bits}
    input  logic [W-1:0] d,         // divisor
    output logic [1:0]   q,         // selected quotient digit
    output logic [W-1:0] r_next     // R' - q*d, always < d so W bits suffice
);
    logic [W+1:0] d1;
    logic [W+1:0] d2;
    logic [W+1:0] d3;
    logic [W+1:0] dsel;

    // Trial multiples of d (3d < 4*2^W fits in W+2 bits); each trial
    // subtraction is non-negative exactly when R' >= q*d, so the digit is
    // chosen by comparison and only the winning difference is formed.
    always_comb begin
        d1   = {2'b00, d};
        d2   = {1'b0, d, 1'b0};
        d3   = d1 + d2;
        q    = 2'd0;
        dsel = '0;
        if (r_shift >= d3) begin
            q    = 2'd3;
            dsel = d3;
        end else if (r_shift >= d2) begin
            q    = 2'd2;
            dsel = d2;
        end else if (r_shift >= d1) begin
            q    = 2'd1;
            dsel = d1;
        end
        r_next = W'(r_shift - dsel);
    end

endmodule

// File: rtl/div16by8_r4_seq.sv
// Sequential unsigned 2W/W divider, radix-4 restoring, two quotient bits
// per cycle, with valid/ready handshakes on the operand and result sides.
module div16by8_r4_seq
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);
    localparam int CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W / 2 - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     r_q, r_d;        // partial remainder (always < divisor)
    logic [W-1:0]     lo_q, lo_d;      // unconsumed low dividend bits, MSB first
    logic [W-1:0]     d_q, d_d;        // latched divisor
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W+1:0]     step_r_shift;
    logic [1:0]       step_q;
    logic [W-1:0]     step_r_next;

    assign step_r_shift = {r_q, lo_q[W-1:W-2]};

    div_r4_step #(.W(W)) u_step (
        .r_shift (step_r_shift),
        .d       (d_q),
        .q       (step_q),
        .r_next  (step_r_next)
    );

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    // Next-state and datapath update: accept/classify, iterate, hand off.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        lo_d    = lo_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d = divisor;
                    if (divisor == '0) begin
                        // Divide by zero: saturated quotient, low half passes through.
                        quo_d   = '1;
                        rem_d   = dividend[W-1:0];
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else if (dividend[2*W-1:W] >= divisor) begin
                        // Quotient would need more than W bits.
                        quo_d   = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        r_d     = dividend[2*W-1:W];
                        lo_d    = dividend[W-1:0];
                        quo_d   = '0;
                        rem_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = step_r_next;
                lo_d  = {lo_q[W-3:0], 2'b00};
                quo_d = {quo_q[W-3:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    rem_d   = step_r_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            lo_q    <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            lo_q    <= lo_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
